// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage and a DMA burst engine.
// The CPU has priority; a per-beat wait counter forces a DMA beat (stalling the CPU) after MAX_WAIT losses.
module dmem_arbiter #(
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cpu_req,
    input  logic             i_cpu_wren,
    input  logic [31:0]      i_cpu_addr,
    input  logic [31:0]      i_cpu_wdata,
    input  logic [2:0]       i_cpu_funct3,
    output logic [31:0]      o_cpu_rdata,
    output logic             o_cpu_stall,
    input  logic             i_dma_start,
    input  logic             i_dma_wr,
    input  logic [31:0]      i_dma_base,
    input  logic [LEN_W-1:0] i_dma_len,
    output logic             o_dma_busy,
    output logic             o_dma_done,
    input  logic [31:0]      i_dma_wdata,
    input  logic             i_dma_wvalid,
    output logic             o_dma_wready,
    output logic [31:0]      o_dma_rdata,
    output logic             o_dma_rvalid,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    output logic             o_mem_wren,
    output logic             o_mem_ren,
    output logic [2:0]       o_mem_funct3,
    input  logic [31:0]      i_mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t            state, state_nxt;
    logic [31:0]       base;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  idx;
    logic              wr;
    logic [WAIT_W-1:0] wait_cnt;

    logic              eligible;
    logic              dma_grant;
    logic              last_beat;
    logic [31:0]       dma_addr;

    assign eligible  = (state == ACTIVE) && (!wr || i_dma_wvalid);
    assign dma_grant = eligible && (!i_cpu_req || wait_cnt >= WAIT_W'(MAX_WAIT));
    assign last_beat = (idx == len - LEN_W'(1));
    assign dma_addr  = base + (32'(idx) << 2);

    assign o_cpu_rdata = i_mem_rdata;
    assign o_dma_busy  = (state == ACTIVE);
    assign o_dma_done  = (state == DONE);

    always_comb begin
        o_mem_addr   = i_cpu_addr;
        o_mem_wdata  = i_cpu_wdata;
        o_mem_funct3 = i_cpu_funct3;
        o_mem_wren   = i_cpu_req && i_cpu_wren;
        o_mem_ren    = i_cpu_req && !i_cpu_wren;
        o_cpu_stall  = 1'b0;
        o_dma_wready = 1'b0;
        state_nxt    = state;

        case (state)
            IDLE: begin
                if (i_dma_start)
                    state_nxt = (i_dma_len == '0) ? DONE : ACTIVE;
            end
            ACTIVE: begin
                if (dma_grant) begin
                    o_mem_addr   = dma_addr;
                    o_mem_wdata  = i_dma_wdata;
                    o_mem_funct3 = 3'b010;
                    o_mem_wren   = wr;
                    o_mem_ren    = !wr;
                    o_dma_wready = wr;
                    o_cpu_stall  = i_cpu_req;
                    if (last_beat)
                        state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Nothing may touch memory or hold the pipeline while reset is asserted.
        if (!i_reset) begin
            o_mem_wren   = 1'b0;
            o_mem_ren    = 1'b0;
            o_cpu_stall  = 1'b0;
            o_dma_wready = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= IDLE;
            base         <= '0;
            len          <= '0;
            wr           <= 1'b0;
            idx          <= '0;
            wait_cnt     <= '0;
            o_dma_rdata  <= '0;
            o_dma_rvalid <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_dma_rvalid <= dma_grant && !wr;
            if (dma_grant && !wr)
                o_dma_rdata <= i_mem_rdata;

            if (state == IDLE && i_dma_start) begin
                base     <= i_dma_base & ~32'h3;
                len      <= i_dma_len;
                wr       <= i_dma_wr;
                idx      <= '0;
                wait_cnt <= '0;
            end else if (dma_grant) begin
                idx      <= idx + LEN_W'(1);
                wait_cnt <= '0;
            end else if (eligible && i_cpu_req && wait_cnt < WAIT_W'(MAX_WAIT)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural word memory on the shared port.
module tb_dmem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cpu_req, i_cpu_wren;
    logic [31:0] i_cpu_addr, i_cpu_wdata;
    logic [2:0]  i_cpu_funct3;
    logic [31:0] o_cpu_rdata;
    logic        o_cpu_stall;
    logic        i_dma_start, i_dma_wr;
    logic [31:0] i_dma_base;
    logic [7:0]  i_dma_len;
    logic        o_dma_busy, o_dma_done;
    logic [31:0] i_dma_wdata;
    logic        i_dma_wvalid, o_dma_wready;
    logic [31:0] o_dma_rdata;
    logic        o_dma_rvalid;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        o_mem_wren, o_mem_ren;
    logic [2:0]  o_mem_funct3;
    logic [31:0] i_mem_rdata;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem [0:255];

    always #5 i_clk = ~i_clk;

    assign i_mem_rdata = mem[o_mem_addr[9:2]];
    always @(posedge i_clk) if (o_mem_wren) mem[o_mem_addr[9:2]] <= o_mem_wdata;

    dmem_arbiter #(.LEN_W(8), .MAX_WAIT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cpu_req(i_cpu_req), .i_cpu_wren(i_cpu_wren), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .i_cpu_funct3(i_cpu_funct3),
        .o_cpu_rdata(o_cpu_rdata), .o_cpu_stall(o_cpu_stall),
        .i_dma_start(i_dma_start), .i_dma_wr(i_dma_wr), .i_dma_base(i_dma_base),
        .i_dma_len(i_dma_len), .o_dma_busy(o_dma_busy), .o_dma_done(o_dma_done),
        .i_dma_wdata(i_dma_wdata), .i_dma_wvalid(i_dma_wvalid), .o_dma_wready(o_dma_wready),
        .o_dma_rdata(o_dma_rdata), .o_dma_rvalid(o_dma_rvalid),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wren(o_mem_wren),
        .o_mem_ren(o_mem_ren), .o_mem_funct3(o_mem_funct3), .i_mem_rdata(i_mem_rdata)
    );

    task automatic set_cpu(input logic req, input logic wren, input logic [31:0] addr,
                           input logic [31:0] wdata);
        i_cpu_req = req; i_cpu_wren = wren; i_cpu_addr = addr; i_cpu_wdata = wdata;
        i_cpu_funct3 = 3'b010;
    endtask

    task automatic set_start(input logic go, input logic wr, input logic [31:0] base,
                             input logic [7:0] len);
        i_dma_start = go; i_dma_wr = wr; i_dma_base = base; i_dma_len = len;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        set_cpu(1'b1, 1'b1, 32'h100, 32'h1234);
        set_start(1'b0, 1'b0, 32'h0, 8'd0);
        i_dma_wdata = '0; i_dma_wvalid = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        checks++; if (o_mem_wren !== 1'b0) begin fails++; $display("FAIL reset_wren act=%b exp=0", o_mem_wren); end
        checks++; if (o_mem_ren !== 1'b0) begin fails++; $display("FAIL reset_ren act=%b exp=0", o_mem_ren); end
        checks++; if (o_cpu_stall !== 1'b0 || o_dma_wready !== 1'b0) begin fails++; $display("FAIL reset_stall_wready act=%b%b exp=00", o_cpu_stall, o_dma_wready); end
        checks++; if ({o_dma_busy, o_dma_done, o_dma_rvalid} !== 3'b000) begin fails++; $display("FAIL reset_flags act=%b exp=000", {o_dma_busy, o_dma_done, o_dma_rvalid}); end
        checks++; if (o_dma_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata act=%h exp=0", o_dma_rdata); end
        @(negedge i_clk);
        i_reset = 1'b1; i_dma_wvalid = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_idle_passthrough();
        @(negedge i_clk);
        set_cpu(1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
        #1;
        checks++; if (o_mem_wren !== 1'b1 || o_mem_addr !== 32'h100) begin fails++; $display("FAIL idle_store act=%b/%h exp=1/00000100", o_mem_wren, o_mem_addr); end
        checks++; if (o_cpu_stall !== 1'b0) begin fails++; $display("FAIL idle_store_stall act=%b exp=0", o_cpu_stall); end
        @(negedge i_clk);
        set_cpu(1'b1, 1'b0, 32'h100, 32'h0);
        #1;
        checks++; if (o_mem_ren !== 1'b1 || o_mem_wren !== 1'b0) begin fails++; $display("FAIL idle_load_en act=%b%b exp=10", o_mem_ren, o_mem_wren); end
        checks++; if (o_cpu_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL idle_load_data act=%h exp=deadbeef", o_cpu_rdata); end
        checks++; if (o_cpu_stall !== 1'b0) begin fails++; $display("FAIL idle_load_stall act=%b exp=0", o_cpu_stall); end
        // Preload 0x200/0x204/0x208 = 1/2/3 through the CPU path.
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            set_cpu(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'(i + 1));
        end
    endtask

    task automatic test_read_burst();
        @(negedge i_clk);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_start(1'b1, 1'b0, 32'h200, 8'd3);
        #1;
        checks++; if (o_dma_busy !== 1'b0) begin fails++; $display("FAIL rd_start_busy act=%b exp=0", o_dma_busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            set_start(1'b0, 1'b0, 32'h0, 8'd0);
            #1;
            checks++; if (o_dma_busy !== 1'b1 || o_mem_ren !== 1'b1 || o_mem_addr !== 32'h200 + 32'(4 * k)) begin
                fails++; $display("FAIL rd_beat%0d act=busy%b ren%b addr%h exp=busy1 ren1 addr%h", k, o_dma_busy, o_mem_ren, o_mem_addr, 32'h200 + 32'(4 * k)); end
            checks++; if (o_mem_funct3 !== 3'b010 || o_cpu_stall !== 1'b0) begin fails++; $display("FAIL rd_beat%0d_f3 act=%b/%b exp=010/0", k, o_mem_funct3, o_cpu_stall); end
            checks++; if (o_dma_rvalid !== (k > 0) || o_dma_done !== 1'b0) begin fails++; $display("FAIL rd_rvalid%0d act=%b done%b exp=%b done0", k, o_dma_rvalid, o_dma_done, k > 0); end
            if (k > 0) begin
                checks++; if (o_dma_rdata !== 32'(k)) begin fails++; $display("FAIL rd_data%0d act=%h exp=%h", k, o_dma_rdata, 32'(k)); end
            end
        end
        @(negedge i_clk); #1;
        checks++; if (o_dma_done !== 1'b1 || o_dma_busy !== 1'b0) begin fails++; $display("FAIL rd_done act=done%b busy%b exp=done1 busy0", o_dma_done, o_dma_busy); end
        checks++; if (o_dma_rvalid !== 1'b1 || o_dma_rdata !== 32'd3) begin fails++; $display("FAIL rd_last act=%b/%h exp=1/00000003", o_dma_rvalid, o_dma_rdata); end
        @(negedge i_clk); #1;
        checks++; if (o_dma_done !== 1'b0 || o_dma_rvalid !== 1'b0) begin fails++; $display("FAIL rd_after act=done%b rv%b exp=00", o_dma_done, o_dma_rvalid); end
    endtask

    task automatic test_starvation();
        logic        st;
        logic [31:0] ea;
        @(negedge i_clk);
        set_cpu(1'b1, 1'b1, 32'h100, 32'h55);
        set_start(1'b1, 1'b0, 32'h200, 8'd2);
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            set_start(1'b0, 1'b0, 32'h0, 8'd0);
            #1;
            st = (k == 4) || (k == 9);
            ea = (k == 4) ? 32'h200 : (k == 9) ? 32'h204 : 32'h100;
            checks++; if (o_cpu_stall !== st || o_mem_addr !== ea || o_mem_wren !== !st || o_mem_ren !== st) begin
                fails++; $display("FAIL starve_c%0d act=stall%b addr%h wren%b ren%b exp=stall%b addr%h wren%b ren%b", k, o_cpu_stall, o_mem_addr, o_mem_wren, o_mem_ren, st, ea, !st, st); end
            if (k == 5) begin
                checks++; if (o_dma_rvalid !== 1'b1 || o_dma_rdata !== 32'd1) begin fails++; $display("FAIL starve_rv0 act=%b/%h exp=1/00000001", o_dma_rvalid, o_dma_rdata); end
            end
        end
        @(negedge i_clk); #1;
        checks++; if (o_dma_done !== 1'b1 || o_cpu_stall !== 1'b0 || o_mem_wren !== 1'b1) begin fails++; $display("FAIL starve_done act=done%b stall%b wren%b exp=101", o_dma_done, o_cpu_stall, o_mem_wren); end
        checks++; if (o_dma_rvalid !== 1'b1 || o_dma_rdata !== 32'd2) begin fails++; $display("FAIL starve_rv1 act=%b/%h exp=1/00000002", o_dma_rvalid, o_dma_rdata); end
    endtask

    task automatic test_write_gaps();
        logic v;
        @(negedge i_clk);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_start(1'b1, 1'b1, 32'h300, 8'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            set_start(1'b0, 1'b0, 32'h0, 8'd0);
            v = (k == 0) || (k == 3);
            i_dma_wvalid = v;
            i_dma_wdata  = (k == 0) ? 32'hA0 : 32'hA1;
            #1;
            checks++; if (o_dma_wready !== v || o_mem_wren !== v || o_dma_busy !== 1'b1) begin
                fails++; $display("FAIL wr_c%0d act=wready%b wren%b busy%b exp=wready%b wren%b busy1", k, o_dma_wready, o_mem_wren, o_dma_busy, v, v); end
            if (v) begin
                checks++; if (o_mem_addr !== ((k == 0) ? 32'h300 : 32'h304)) begin fails++; $display("FAIL wr_addr%0d act=%h exp=%h", k, o_mem_addr, (k == 0) ? 32'h300 : 32'h304); end
            end
        end
        @(negedge i_clk);
        i_dma_wvalid = 1'b0;
        #1;
        checks++; if (o_dma_done !== 1'b1) begin fails++; $display("FAIL wr_done act=%b exp=1", o_dma_done); end
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            set_cpu(1'b1, 1'b0, 32'h300 + 32'(4 * k), 32'h0);
            #1;
            checks++; if (o_cpu_rdata !== 32'hA0 + 32'(k)) begin fails++; $display("FAIL wr_mem%0d act=%h exp=%h", k, o_cpu_rdata, 32'hA0 + 32'(k)); end
        end
    endtask

    task automatic test_boundaries();
        @(negedge i_clk);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        set_start(1'b1, 1'b0, 32'h200, 8'd0);
        @(negedge i_clk);
        set_start(1'b0, 1'b0, 32'h0, 8'd0);
        #1;
        checks++; if (o_dma_done !== 1'b1 || o_dma_busy !== 1'b0 || o_mem_ren !== 1'b0 || o_mem_wren !== 1'b0) begin
            fails++; $display("FAIL len0 act=done%b busy%b ren%b wren%b exp=1000", o_dma_done, o_dma_busy, o_mem_ren, o_mem_wren); end
        @(negedge i_clk); #1;
        checks++; if (o_dma_done !== 1'b0) begin fails++; $display("FAIL len0_pulse act=%b exp=0", o_dma_done); end
        // Address wrap across 2^32.
        @(negedge i_clk);
        set_start(1'b1, 1'b1, 32'hFFFFFFFC, 8'd2);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            set_start(1'b0, 1'b0, 32'h0, 8'd0);
            i_dma_wvalid = 1'b1; i_dma_wdata = 32'hC0 + 32'(k);
            #1;
            checks++; if (o_mem_wren !== 1'b1 || o_mem_addr !== ((k == 0) ? 32'hFFFFFFFC : 32'h0)) begin
                fails++; $display("FAIL wrap%0d act=wren%b addr%h exp=wren1 addr%h", k, o_mem_wren, o_mem_addr, (k == 0) ? 32'hFFFFFFFC : 32'h0); end
        end
        @(negedge i_clk);
        i_dma_wvalid = 1'b0;
        #1;
        checks++; if (o_dma_done !== 1'b1) begin fails++; $display("FAIL wrap_done act=%b exp=1", o_dma_done); end
        // Unaligned base is aligned down.
        @(negedge i_clk);
        set_start(1'b1, 1'b0, 32'h203, 8'd1);
        @(negedge i_clk);
        set_start(1'b0, 1'b0, 32'h0, 8'd0);
        #1;
        checks++; if (o_mem_ren !== 1'b1 || o_mem_addr !== 32'h200) begin fails++; $display("FAIL align act=ren%b addr%h exp=ren1 addr00000200", o_mem_ren, o_mem_addr); end
        @(negedge i_clk); #1;
        checks++; if (o_dma_done !== 1'b1 || o_dma_rdata !== 32'd1) begin fails++; $display("FAIL align_done act=%b/%h exp=1/00000001", o_dma_done, o_dma_rdata); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge i_clk);
        set_start(1'b1, 1'b0, 32'h200, 8'd4);
        @(negedge i_clk);
        set_start(1'b0, 1'b0, 32'h0, 8'd0);
        #1;
        checks++; if (o_mem_ren !== 1'b1 || o_mem_addr !== 32'h200) begin fails++; $display("FAIL rstmid_b0 act=ren%b addr%h exp=ren1 addr00000200", o_mem_ren, o_mem_addr); end
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        checks++; if (o_mem_ren !== 1'b0) begin fails++; $display("FAIL rstmid_forced act=%b exp=0", o_mem_ren); end
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (o_dma_busy !== 1'b0 || o_dma_done !== 1'b0 || o_mem_ren !== 1'b0 || o_dma_rvalid !== 1'b0) begin
                fails++; $display("FAIL rstmid_quiet%0d act=busy%b done%b ren%b rv%b exp=0000", k, o_dma_busy, o_dma_done, o_mem_ren, o_dma_rvalid); end
            @(negedge i_clk);
        end
        set_start(1'b1, 1'b0, 32'h204, 8'd1);
        @(negedge i_clk);
        set_start(1'b0, 1'b0, 32'h0, 8'd0);
        #1;
        checks++; if (o_mem_ren !== 1'b1 || o_mem_addr !== 32'h204 || o_dma_busy !== 1'b1) begin fails++; $display("FAIL rstmid_new act=ren%b addr%h busy%b exp=ren1 addr00000204 busy1", o_mem_ren, o_mem_addr, o_dma_busy); end
        @(negedge i_clk); #1;
        checks++; if (o_dma_done !== 1'b1 || o_dma_rvalid !== 1'b1 || o_dma_rdata !== 32'd2) begin
            fails++; $display("FAIL rstmid_new_done act=done%b rv%b data%h exp=done1 rv1 data00000002", o_dma_done, o_dma_rvalid, o_dma_rdata); end
    endtask

    initial begin
        test_reset();
        test_idle_passthrough();
        test_read_burst();
        test_starvation();
        test_write_gaps();
        test_boundaries();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/LSU port between the pipeline MEM stage and a DMA/debug burst engine.
- Sequences word bursts (read or write) from a latched base address and length.
- Gives the CPU priority, but a starvation counter guarantees DMA progress; when DMA is forced through, it stalls the pipeline.
- Sits between the EX/MEM register outputs and the lsu; o_cpu_stall is ORed into the hazard unit's stall_pc/stall_if_id/stall_id_ex and holds EX/MEM.

Parameters:
- LEN_W, 8, width of the burst length field (max 2^LEN_W-1 words).
- MAX_WAIT, 4, consecutive cycles an eligible DMA beat may lose to the CPU before the DMA is forced (must be >=1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous reset, active-low.
- i_cpu_req  in  1  MEM-stage memory access (mem_ren|mem_wren).
- i_cpu_wren  in  1  MEM-stage store.
- i_cpu_addr  in  32  MEM-stage address (alu_data).
- i_cpu_wdata  in  32  MEM-stage store data.
- i_cpu_funct3  in  3  access size/sign.
- o_cpu_rdata  out  32  load data to MEM/WB.
- o_cpu_stall  out  1  CPU access not performed this cycle; hold pipeline.
- i_dma_start  in  1  burst command strobe.
- i_dma_wr  in  1  1=write burst, 0=read burst.
- i_dma_base  in  32  burst base byte address.
- i_dma_len  in  LEN_W  number of words.
- o_dma_busy  out  1  burst in progress.
- o_dma_done  out  1  one-cycle completion pulse.
- i_dma_wdata  in  32  write beat data.
- i_dma_wvalid  in  1  write beat available.
- o_dma_wready  out  1  write beat consumed this cycle.
- o_dma_rdata  out  32  read beat data (registered).
- o_dma_rvalid  out  1  read beat valid pulse.
- o_mem_addr  out  32  shared port address.
- o_mem_wdata  out  32  shared port write data.
- o_mem_wren  out  1  shared port write enable.
- o_mem_ren  out  1  shared port read enable.
- o_mem_funct3  out  3  shared port size.
- i_mem_rdata  in  32  shared port read data (combinational, same cycle).

Behaviour:
- Reset (i_reset=0 at posedge): state IDLE, beat index=0, wait_cnt=0, o_dma_rdata=0, o_dma_rvalid=0, o_dma_done=0, o_dma_busy=0. While i_reset=0, o_mem_wren, o_mem_ren, o_cpu_stall and o_dma_wready are forced 0.
- Reset mid-burst aborts the burst. No done pulse is issued and no further beats occur.
- States are IDLE, ACTIVE and DONE.
- IDLE:
  - The memory port mirrors the CPU (addr, wdata, funct3, wren=i_cpu_req&i_cpu_wren, ren=i_cpu_req&~i_cpu_wren).
  - o_cpu_rdata=i_mem_rdata; o_cpu_stall=0.
  - i_dma_start latches base (bits[1:0] forced 0), len and wr.
  - len!=0 moves to ACTIVE; len==0 moves directly to DONE.
- ACTIVE:
  - o_dma_busy=1. i_dma_start is ignored.
  - A beat is eligible when it is a read, or a write with i_dma_wvalid=1.
  - Arbitration, evaluated combinationally each cycle:
    - i_cpu_req=1 and (not eligible or wait_cnt<MAX_WAIT): CPU owns the port, stall=0. If a beat was eligible, wait_cnt++ (saturating).
    - Eligible and (i_cpu_req=0 or wait_cnt>=MAX_WAIT): DMA owns the port. o_cpu_stall=i_cpu_req, and a stalled CPU access causes no memory write. wait_cnt clears to 0.
  - DMA beat fields: addr=base+4*index (modulo 2^32, wraps silently), funct3=3'b010.
    - Write beat: wdata=i_dma_wdata, o_dma_wready=1 in the same cycle.
    - Read beat: ren=1; o_dma_rdata<=i_mem_rdata and o_dma_rvalid=1 in the next cycle only.
  - After each granted beat, index++. Granting beat len-1 moves to DONE.
  - Write burst with i_dma_wvalid=0: no beat, wait_cnt unchanged, CPU passes through.
- DONE: o_dma_done=1 and o_dma_busy=0 for exactly one cycle, CPU passes through, then IDLE. A read burst's last rvalid coincides with the done cycle.
- o_cpu_stall is 0 in IDLE and DONE. The CPU is never stalled for two consecutive cycles by the same wait window: after a forced beat, wait_cnt restarts from 0.
- Pipeline obligation: while o_cpu_stall=1, EX/MEM holds and presents the identical request next cycle.

Test Plan:
- Idle passthrough: with no DMA, a CPU store of 0xDEADBEEF to 0x100 then a load from 0x100 gives o_mem_wren=1 then o_cpu_rdata=0xDEADBEEF, and o_cpu_stall stays 0.
- Read burst, quiet CPU: base 0x200, len 3, memory at 0x200/0x204/0x208 = 1/2/3. The grant cycles are back-to-back, rvalid pulses carry 1, 2, 3, done pulses once with the last rvalid, and busy lasts 3 cycles.
- Starvation, MAX_WAIT=4: continuous i_cpu_req during a len-2 read burst gives the CPU 4 cycles, then the DMA is forced with o_cpu_stall=1 for 1 cycle, then 4 CPU cycles, then the second forced beat, then done.
- Write burst with gaps: len 2 with i_dma_wvalid asserted on cycles 0 and 3 gives wready only on those cycles, writes land at base and base+4, and done follows.
- Boundaries: len=0 gives a done pulse the next cycle with no memory access. Base 0xFFFFFFFC with len 2 writes 0xFFFFFFFC then 0x00000000. Base 0x203 is issued as 0x200.
- Reset mid-burst: i_reset=0 during beat 1 of a len-4 read means no further mem access, busy=0, done never pulses, and a new start after reset executes normally.
